alu_op_sequencer: RTL and testbench
===================================

ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 SHALL have parameter WORD_W, default 8, ALU word width in bits.
REQ-002 SHALL have parameter MAX_WORDS, default 8, maximum words per command (power of two).
REQ-003 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have ports cmd_valid in 1 / cmd_ready out 1: command handshake.
REQ-006 SHALL have ports cmd_opsel in 3, cmd_mode in 1, cmd_cin in 1, cmd_words in $clog2(MAX_WORDS): op select, mode (0 arith, 1 logic), initial carry, word count (0 encodes MAX_WORDS).
REQ-007 SHALL have ports alu_opsel out 3, alu_mode out 1, alu_cin out 1, alu_idx out $clog2(MAX_WORDS): drive the external ALU and operand file.
REQ-008 SHALL have ports alu_result in WORD_W, alu_c_flag in 1: combinational ALU result and selected carry flag for the word at alu_idx.
REQ-009 SHALL have ports res_we out 1, res_idx out $clog2(MAX_WORDS), res_data out WORD_W: result-file write.
REQ-010 SHALL have ports rsp_valid out 1 / rsp_ready in 1, rsp_c out 1, rsp_z out 1: completion handshake with final carry and all-words-zero flag.

Function
REQ-011 SHALL implement FSM IDLE -> EXEC -> DONE -> IDLE.
REQ-012 cmd_ready SHALL be 1 only in IDLE; cmd_valid&&cmd_ready in cycle T SHALL latch opsel/mode/cin/count and enter EXEC at T+1.
REQ-013 EXEC SHALL process one word per cycle, idx 0..N-1, res_we=1, res_idx=alu_idx, res_data=alu_result every EXEC cycle.
REQ-014 alu_opsel/alu_mode SHALL equal the latched command throughout EXEC; 0 in IDLE/DONE.
REQ-015 alu_cin SHALL be cmd_cin for word 0 and the alu_c_flag captured at word k-1 for word k when mode=0; 0 whenever mode=1.
REQ-016 Carry register SHALL capture alu_c_flag each EXEC cycle; zero register SHALL be AND of (alu_result==0) over all words, initialised to 1 on accept.
REQ-017 After word N-1 (cycle T+N), FSM SHALL enter DONE at T+N+1 with rsp_valid=1, rsp_c=carry reg, rsp_z=zero reg.
REQ-018 rsp_valid and rsp_c/rsp_z SHALL hold stable until rsp_ready=1; rsp_valid&&rsp_ready SHALL return to IDLE next cycle; no new command accepted in the same cycle.
REQ-019 cmd_words=0 SHALL execute MAX_WORDS words; idx SHALL never wrap past N-1.
REQ-020 cmd_valid in EXEC/DONE SHALL be ignored (not consumed).

Reset
REQ-021 rst_n low SHALL immediately force IDLE, cmd_ready=1 after release, and all other outputs 0, including mid-EXEC (pending writes dropped, no rsp).
REQ-022 Carry register SHALL reset to 0, zero register to 1, idx to 0.

Configuration
REQ-023 Macro ALU_SEQ_ABORT_EN defined SHALL add input abort (1 bit) and output rsp_abort (1 bit): abort=1 in EXEC SHALL suppress that cycle's res_we and enter DONE next cycle with rsp_abort=1, rsp_c=0, rsp_z=0; abort ignored in IDLE/DONE.
REQ-024 Without ALU_SEQ_ABORT_EN, SHALL have neither port and always run all N words.

Structure
REQ-025 alu_seq_pkg SHALL hold the state enum, opsel localparams (matching ALU encoding), and default WORD_W/MAX_WORDS constants.
REQ-026 Carry/zero accumulation SHALL be a sub-module alu_seq_flag_acc (clear, capture enable, c_in, result in; c, z out).

Verification
REQ-027 Add, N=3, cin=0, ALU c_flag 1,1,0 -> alu_cin 0,1,1 on idx 0,1,2; rsp_valid at T+4; rsp_c=0.
REQ-028 Logic op mode=1, N=2, results 0x00,0x00 -> alu_cin 0 both cycles; rsp_z=1, rsp_c=0.
REQ-029 cmd_words=0, MAX_WORDS=8 -> exactly 8 res_we pulses, res_idx 0..7, then rsp_valid.
REQ-030 rsp_ready held 0 for 5 cycles -> rsp_valid, rsp_c, rsp_z stable; cmd_ready=0 throughout; IDLE one cycle after rsp_ready=1.
REQ-031 rst_n low at word 2 of N=4 -> outputs 0 at once, no further res_we, no rsp_valid; next command runs normally from idx 0.
REQ-032 With ALU_SEQ_ABORT_EN, abort at word 1 of N=4 -> res_we only for idx 0; rsp_abort=1 next cycle.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// -----------------------------------------------------------------------------
// alu_seq_pkg
// Shared definitions for the multi-word ALU operation sequencer:
//   - sequencer state encoding
//   - op-select encodings as presented to the external ALU
//   - default word width / command length
// No ports (package).
// -----------------------------------------------------------------------------
package alu_seq_pkg;

    localparam int DEF_WORD_W    = 8;
    localparam int DEF_MAX_WORDS = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } seq_state_t;

    // Op-select values understood by the external ALU. The same 3-bit code
    // means an arithmetic op when mode=0 and a bitwise op when mode=1.
    localparam logic [2:0] OP_ADD = 3'd0;   // mode 0: A + B + cin
    localparam logic [2:0] OP_SUB = 3'd1;   // mode 0: A - B - !cin
    localparam logic [2:0] OP_INC = 3'd2;   // mode 0: A + cin
    localparam logic [2:0] OP_DEC = 3'd3;   // mode 0: A - !cin
    localparam logic [2:0] OP_AND = 3'd0;   // mode 1: A & B
    localparam logic [2:0] OP_OR  = 3'd1;   // mode 1: A | B
    localparam logic [2:0] OP_XOR = 3'd2;   // mode 1: A ^ B
    localparam logic [2:0] OP_NOT = 3'd3;   // mode 1: ~A

endpackage

// File: rtl/alu_seq_flag_acc.sv
// -----------------------------------------------------------------------------
// alu_seq_flag_acc
// Carry / all-zero accumulator for one multi-word command.
//   clk       in   clock, state on rising edge
//   rst_n     in   asynchronous active-low reset (carry 0, zero 1)
//   i_clear   in   start of a new command: carry 0, zero 1
//   i_cap_en  in   capture this word's carry and fold its zero test
//   i_c_in    in   carry flag of the current word
//   i_result  in   result of the current word
//   o_c       out  carry captured at the most recent word
//   o_z       out  1 while every captured word result has been zero
// -----------------------------------------------------------------------------
module alu_seq_flag_acc
    import alu_seq_pkg::*;
#(
    parameter int WORD_W = DEF_WORD_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_clear,
    input  logic              i_cap_en,
    input  logic              i_c_in,
    input  logic [WORD_W-1:0] i_result,
    output logic              o_c,
    output logic              o_z
);

    logic r_c;
    logic r_z;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_c <= 1'b0;
            r_z <= 1'b1;
        end else if (i_clear) begin
            r_c <= 1'b0;
            r_z <= 1'b1;
        end else if (i_cap_en) begin
            r_c <= i_c_in;
            r_z <= r_z & (i_result == '0);
        end
    end

    assign o_c = r_c;
    assign o_z = r_z;

endmodule

// File: rtl/alu_op_sequencer.sv
// -----------------------------------------------------------------------------
// alu_op_sequencer
// Runs one ALU operation across N words (one word per clock), chaining the
// carry between words in arithmetic mode, writing each word's result to a
// result file and reporting the final carry and an all-words-zero flag.
//
// Optional feature (macro ALU_SEQ_ABORT_EN): adds input abort / output
// rsp_abort. Abort during EXEC drops that word's write and finishes early
// with rsp_abort=1 and cleared flags.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   cmd_valid / cmd_ready      command handshake (ready only in IDLE)
//   cmd_opsel, cmd_mode,
//   cmd_cin, cmd_words         op, mode (0 arith / 1 logic), initial carry,
//                              word count (0 means MAX_WORDS)
//   alu_opsel, alu_mode,
//   alu_cin, alu_idx           drive to the external ALU / operand file
//   alu_result, alu_c_flag     combinational ALU result for word alu_idx
//   res_we, res_idx, res_data  result-file write port
//   rsp_valid / rsp_ready      completion handshake
//   rsp_c, rsp_z               final carry, all-words-zero
//   abort, rsp_abort           only with ALU_SEQ_ABORT_EN
// -----------------------------------------------------------------------------
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int WORD_W    = DEF_WORD_W,
    parameter int MAX_WORDS = DEF_MAX_WORDS
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [2:0]                   cmd_opsel,
    input  logic                         cmd_mode,
    input  logic                         cmd_cin,
    input  logic [$clog2(MAX_WORDS)-1:0] cmd_words,
    output logic [2:0]                   alu_opsel,
    output logic                         alu_mode,
    output logic                         alu_cin,
    output logic [$clog2(MAX_WORDS)-1:0] alu_idx,
    input  logic [WORD_W-1:0]            alu_result,
    input  logic                         alu_c_flag,
    output logic                         res_we,
    output logic [$clog2(MAX_WORDS)-1:0] res_idx,
    output logic [WORD_W-1:0]            res_data,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic                         rsp_c,
    output logic                         rsp_z
`ifdef ALU_SEQ_ABORT_EN
    ,
    input  logic                         abort,
    output logic                         rsp_abort
`endif
);

    localparam int IDX_W = $clog2(MAX_WORDS);

    seq_state_t       r_state;
    seq_state_t       w_state_nxt;

    logic [2:0]       r_opsel;
    logic             r_mode;
    logic             r_cin;
    logic [IDX_W-1:0] r_last;
    logic [IDX_W-1:0] r_idx;

    logic             w_accept;
    logic             w_last_word;
    logic             w_abort_now;
    logic             w_aborted;
    logic             w_clear;
    logic             w_cap_en;
    logic             w_acc_c;
    logic             w_acc_z;

    assign w_accept    = (r_state == ST_IDLE) && cmd_valid;
    assign w_last_word = (r_idx == r_last);

`ifdef ALU_SEQ_ABORT_EN
    logic r_abort;

    assign w_abort_now = abort;
    assign w_aborted   = r_abort;
    assign rsp_abort   = rsp_valid & r_abort;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_abort <= 1'b0;
        end else if (w_accept) begin
            r_abort <= 1'b0;
        end else if (r_state == ST_EXEC && abort) begin
            r_abort <= 1'b1;
        end
    end
`else
    assign w_abort_now = 1'b0;
    assign w_aborted   = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and per-state outputs
    always_comb begin
        w_state_nxt = r_state;
        cmd_ready   = 1'b0;
        alu_opsel   = 3'd0;
        alu_mode    = 1'b0;
        alu_cin     = 1'b0;
        res_we      = 1'b0;
        res_data    = '0;
        rsp_valid   = 1'b0;
        w_clear     = 1'b0;
        w_cap_en    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    w_clear     = 1'b1;
                    w_state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                alu_opsel = r_opsel;
                alu_mode  = r_mode;
                // Word 0 takes the command's carry; later words take the
                // carry the ALU produced for the previous word.
                if (!r_mode) begin
                    alu_cin = (r_idx == '0) ? r_cin : w_acc_c;
                end
                res_data = alu_result;
                res_we   = ~w_abort_now;
                w_cap_en = ~w_abort_now;
                if (w_abort_now || w_last_word) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Command latch and word index. The index is returned to 0 when EXEC
    // ends so alu_idx/res_idx read 0 outside EXEC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_opsel <= 3'd0;
            r_mode  <= 1'b0;
            r_cin   <= 1'b0;
            r_last  <= '0;
            r_idx   <= '0;
        end else if (w_accept) begin
            r_opsel <= cmd_opsel;
            r_mode  <= cmd_mode;
            r_cin   <= cmd_cin;
            // MAX_WORDS is a power of two, so a count of 0 wraps to
            // MAX_WORDS-1 here, giving the full-length command.
            r_last  <= cmd_words - 1'b1;
            r_idx   <= '0;
        end else if (r_state == ST_EXEC) begin
            if (w_abort_now || w_last_word) begin
                r_idx <= '0;
            end else begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

    alu_seq_flag_acc #(
        .WORD_W (WORD_W)
    ) u_flag_acc (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clear  (w_clear),
        .i_cap_en (w_cap_en),
        .i_c_in   (alu_c_flag),
        .i_result (alu_result),
        .o_c      (w_acc_c),
        .o_z      (w_acc_z)
    );

    assign alu_idx = r_idx;
    assign res_idx = r_idx;

    // Flags are only presented with a response; an aborted command reports
    // both as 0.
    assign rsp_c = rsp_valid & ~w_aborted & w_acc_c;
    assign rsp_z = rsp_valid & ~w_aborted & w_acc_z;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_op_sequencer
// Self-checking bench for alu_op_sequencer. The bench plays the external ALU
// from per-command tables of word results and carry flags, and predicts every
// output from those tables and the command fields.
// -----------------------------------------------------------------------------
module tb_alu_op_sequencer;
    import alu_seq_pkg::*;

    localparam int WORD_W    = 8;
    localparam int MAX_WORDS = 8;
    localparam int IDX_W     = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [2:0]        cmd_opsel;
    logic              cmd_mode;
    logic              cmd_cin;
    logic [IDX_W-1:0]  cmd_words;
    logic [2:0]        alu_opsel;
    logic              alu_mode;
    logic              alu_cin;
    logic [IDX_W-1:0]  alu_idx;
    logic [WORD_W-1:0] alu_result;
    logic              alu_c_flag;
    logic              res_we;
    logic [IDX_W-1:0]  res_idx;
    logic [WORD_W-1:0] res_data;
    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_c;
    logic              rsp_z;
`ifdef ALU_SEQ_ABORT_EN
    logic              abort;
    logic              rsp_abort;
`endif

    logic [WORD_W-1:0] m_res [MAX_WORDS];
    logic              m_cf  [MAX_WORDS];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Behavioural ALU: result and carry for the word being addressed.
    assign alu_result = m_res[alu_idx];
    assign alu_c_flag = m_cf[alu_idx];

    alu_op_sequencer #(
        .WORD_W    (WORD_W),
        .MAX_WORDS (MAX_WORDS)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_opsel  (cmd_opsel),
        .cmd_mode   (cmd_mode),
        .cmd_cin    (cmd_cin),
        .cmd_words  (cmd_words),
        .alu_opsel  (alu_opsel),
        .alu_mode   (alu_mode),
        .alu_cin    (alu_cin),
        .alu_idx    (alu_idx),
        .alu_result (alu_result),
        .alu_c_flag (alu_c_flag),
        .res_we     (res_we),
        .res_idx    (res_idx),
        .res_data   (res_data),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_c      (rsp_c),
        .rsp_z      (rsp_z)
`ifdef ALU_SEQ_ABORT_EN
        ,
        .abort      (abort),
        .rsp_abort  (rsp_abort)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < MAX_WORDS; i++) begin
            m_res[i] = ($urandom_range(0, 2) == 0) ? '0 : WORD_W'($urandom);
            m_cf[i]  = 1'($urandom);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_res_we"},    32'(res_we),    32'd0);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_alu_opsel"}, 32'(alu_opsel), 32'd0);
        check({tag, "_alu_mode"},  32'(alu_mode),  32'd0);
        check({tag, "_alu_cin"},   32'(alu_cin),   32'd0);
        check({tag, "_alu_idx"},   32'(alu_idx),   32'd0);
        check({tag, "_rsp_c"},     32'(rsp_c),     32'd0);
        check({tag, "_rsp_z"},     32'(rsp_z),     32'd0);
    endtask

    // One full command. Inputs change and outputs are sampled on the falling
    // edge. With noisy=1, cmd_valid stays high with altered fields while the
    // command is running, and is still high on the response handshake cycle.
    task automatic run_cmd(input logic [2:0] op, input logic mode, input logic cin,
                           input logic [IDX_W-1:0] words, input int ready_delay,
                           input bit noisy);
        int   n;
        logic exp_c;
        logic exp_z;
        logic exp_cin;

        n = (words == 0) ? MAX_WORDS : int'(words);
        exp_z = 1'b1;
        for (int i = 0; i < n; i++) begin
            if (m_res[i] != 0) exp_z = 1'b0;
        end
        exp_c = (mode == 1'b0 || 1'b1) ? m_cf[n-1] : 1'b0;

        check("idle_cmd_ready", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_opsel = op;
        cmd_mode  = mode;
        cmd_cin   = cin;
        cmd_words = words;
        @(posedge clk);
        @(negedge clk);
        if (noisy) begin
            cmd_opsel = ~op;
            cmd_mode  = ~mode;
            cmd_cin   = ~cin;
            cmd_words = words + 3'd3;
        end else begin
            cmd_valid = 1'b0;
        end

        for (int k = 0; k < n; k++) begin
            rsp_ready = 1'($urandom);
            if (mode)        exp_cin = 1'b0;
            else if (k == 0) exp_cin = cin;
            else             exp_cin = m_cf[k-1];
            check("exec_cmd_ready", 32'(cmd_ready), 32'd0);
            check("exec_res_we",    32'(res_we),    32'd1);
            check("exec_res_idx",   32'(res_idx),   32'(k));
            check("exec_alu_idx",   32'(alu_idx),   32'(k));
            check("exec_res_data",  32'(res_data),  32'(m_res[k]));
            check("exec_alu_cin",   32'(alu_cin),   32'(exp_cin));
            check("exec_alu_opsel", 32'(alu_opsel), 32'(op));
            check("exec_alu_mode",  32'(alu_mode),  32'(mode));
            check("exec_rsp_valid", 32'(rsp_valid), 32'd0);
            @(posedge clk);
            @(negedge clk);
        end

        for (int d = 0; d <= ready_delay; d++) begin
            check("done_rsp_valid", 32'(rsp_valid), 32'd1);
            check("done_rsp_c",     32'(rsp_c),     32'(exp_c));
            check("done_rsp_z",     32'(rsp_z),     32'(exp_z));
            check("done_cmd_ready", 32'(cmd_ready), 32'd0);
            check("done_res_we",    32'(res_we),    32'd0);
            check("done_alu_opsel", 32'(alu_opsel), 32'd0);
            check("done_alu_cin",   32'(alu_cin),   32'd0);
`ifdef ALU_SEQ_ABORT_EN
            check("done_rsp_abort", 32'(rsp_abort), 32'd0);
`endif
            rsp_ready = (d == ready_delay);
            @(posedge clk);
            @(negedge clk);
        end
        rsp_ready = 1'b0;
        check("after_rsp_valid", 32'(rsp_valid), 32'd0);
        check("after_cmd_ready", 32'(cmd_ready), 32'd1);
        check("after_res_we",    32'(res_we),    32'd0);
        cmd_valid = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_opsel = 3'd0;
        cmd_mode  = 1'b0;
        cmd_cin   = 1'b0;
        cmd_words = '0;
        rsp_ready = 1'b0;
`ifdef ALU_SEQ_ABORT_EN
        abort     = 1'b0;
`endif
        for (int i = 0; i < MAX_WORDS; i++) begin
            m_res[i] = '0;
            m_cf[i]  = 1'b0;
        end

        // Reset state
        repeat (2) @(negedge clk);
        check_quiet("rst");
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check_quiet("post_rst");

        // Three-word add with carry chain 1,1,0
        fill_random();
        m_cf[0] = 1'b1; m_cf[1] = 1'b1; m_cf[2] = 1'b0;
        run_cmd(OP_ADD, 1'b0, 1'b0, 3'd3, 0, 1'b0);

        // Logic mode, two zero results
        fill_random();
        m_res[0] = '0; m_res[1] = '0;
        m_cf[0] = 1'b0; m_cf[1] = 1'b0;
        run_cmd(OP_AND, 1'b1, 1'b1, 3'd2, 1, 1'b0);

        // Count 0 runs the full MAX_WORDS words
        fill_random();
        run_cmd(OP_SUB, 1'b0, 1'b1, 3'd0, 0, 1'b0);

        // Response back-pressure for 5 cycles, with a command held pending
        fill_random();
        run_cmd(OP_XOR, 1'b1, 1'b0, 3'd4, 5, 1'b1);

        // Reset in the middle of a four-word command
        fill_random();
        cmd_valid = 1'b1; cmd_opsel = OP_INC; cmd_mode = 1'b0;
        cmd_cin = 1'b1; cmd_words = 3'd4;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        check("midrst_alu_idx", 32'(alu_idx), 32'd2);
        check("midrst_res_we",  32'(res_we),  32'd1);
        rst_n = 1'b0;
        #1;
        check_quiet("midrst_now");
        @(negedge clk);
        check_quiet("midrst_hold");
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
            check_quiet("midrst_after");
        end
        fill_random();
        run_cmd(OP_DEC, 1'b0, 1'b0, 3'd4, 2, 1'b0);

`ifdef ALU_SEQ_ABORT_EN
        // Abort at word 1 of a four-word command
        fill_random();
        cmd_valid = 1'b1; cmd_opsel = OP_ADD; cmd_mode = 1'b0;
        cmd_cin = 1'b0; cmd_words = 3'd4;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("abort_w0_res_we", 32'(res_we), 32'd1);
        @(posedge clk);
        @(negedge clk);
        abort = 1'b1;
        #1;
        check("abort_w1_res_we", 32'(res_we), 32'd0);
        @(posedge clk);
        @(negedge clk);
        abort = 1'b0;
        check("abort_rsp_valid", 32'(rsp_valid), 32'd1);
        check("abort_rsp_abort", 32'(rsp_abort), 32'd1);
        check("abort_rsp_c",     32'(rsp_c),     32'd0);
        check("abort_rsp_z",     32'(rsp_z),     32'd0);
        check("abort_res_we",    32'(res_we),    32'd0);
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        check("abort_cmd_ready", 32'(cmd_ready), 32'd1);
        check("abort_rsp_abort_clr", 32'(rsp_abort), 32'd0);
`endif

        // Randomized commands
        for (int t = 0; t < 40; t++) begin
            fill_random();
            run_cmd(3'($urandom), 1'($urandom), 1'($urandom), IDX_W'($urandom),
                    int'($urandom_range(0, 3)), 1'($urandom));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule
